k_sel_vote: RTL and testbench
=============================

K_SEL_VOTE -- requirements
Module: k_sel_vote

Interface
REQ-001 SHALL have parameter K, default 5, number of nearest neighbours retained (legal 1..16).
REQ-002 SHALL have parameter DIST_W, default 19, distance width in bits.
REQ-003 SHALL have parameter CLASS_W, default 2, class-label width; NCLASS = 2**CLASS_W.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  beat qualifier; in_ready  out  1  beat accept.
REQ-007 SHALL have ports dist_a, dist_b  in  DIST_W, and class_a, class_b  in  CLASS_W  two candidates per beat.
REQ-008 SHALL have port b_en  in  1  lane-b qualifier; lane a always valid on an accepted beat.
REQ-009 SHALL have port in_last  in  1  final beat of the query.
REQ-010 SHALL have ports out_valid  out  1, out_ready  in  1  result handshake.
REQ-011 SHALL have ports vote_class  out  CLASS_W, vote_count  out  5, nearest_dist  out  DIST_W, busy  out  1.

Function
REQ-012 SHALL implement states COLLECT, VOTE, DONE; in_ready = 1 only in COLLECT; busy = 1 in VOTE and DONE.
REQ-013 SHALL, on an accepted beat (in_valid & in_ready), insert lane a and then, if b_en, lane b into the ascending sorted list of K (distance, class, occupied) entries in that same cycle, with the update visible the next cycle.
REQ-014 SHALL insert only on strict less-than against occupied entries (empty entries always accept); equal distances keep arrival order, lane a ahead of lane b.
REQ-015 SHALL drop the entry shifted out of position K-1, and drop a candidate not smaller than a full list's last entry.
REQ-016 SHALL move COLLECT->VOTE on an accepted beat with in_last = 1, after that beat's insertion.
REQ-017 SHALL, in VOTE, evaluate one class per cycle (index 0..NCLASS-1), counting occupied entries with that class; VOTE lasts exactly NCLASS cycles, then DONE.
REQ-018 SHALL replace the running best class only when its count strictly exceeds the best count (tie rule per REQ-025/026).
REQ-019 SHALL, in DONE, hold out_valid = 1 with vote_class, vote_count and nearest_dist (entry 0 distance, all-ones if empty) stable until out_ready.
REQ-020 SHALL, on out_valid & out_ready, clear all entries to unoccupied and return to COLLECT in the next cycle.
REQ-021 SHALL report vote_class = 0, vote_count = 0 and nearest_dist all-ones for a query with zero occupied entries.
REQ-022 SHALL ignore in_valid, in_last and all data inputs outside COLLECT.

Reset
REQ-023 SHALL, while reset_n = 0, force state COLLECT, all entries unoccupied with distance all-ones, and outputs out_valid = 0, vote_class = 0, vote_count = 0, nearest_dist = all-ones, busy = 0; in_ready = 1 after reset.
REQ-024 SHALL abandon any in-progress query on reset assertion mid-COLLECT, mid-VOTE or mid-DONE with no result emitted.

Configuration
REQ-025 SHALL, with K_SEL_TIE_NEAREST_EN defined, break count ties toward the class whose nearest member has the lower list rank.
REQ-026 SHALL, without K_SEL_TIE_NEAREST_EN, break count ties toward the lower class index (first evaluated keeps).

Verification (K=5, CLASS_W=2)
REQ-027 SHALL cover: beats (10,c1)/(4,c2), (7,c1)/(2,c1), last (9,c3)/b_en=0 -> list 2,4,7,9,10; vote_class 1, vote_count 3, nearest_dist 2, out_valid 5 cycles after last beat.
REQ-028 SHALL cover: 7 beats with distances 20 down to 7 both lanes -> only five smallest kept, oldest equal distances retained ahead of newer.
REQ-029 SHALL cover: lanes (5,c2)/(5,c3), last (6,c3)/(6,c2), b_en=1 -> counts 2/2; with macro vote_class 2, without vote_class 2 (lower index); swap labels to show macro-only winner 3.
REQ-030 SHALL cover: single beat in_last=1, b_en=0, dist 0 -> vote_count 1, nearest_dist 0; empty-list boundary via reset then immediate in_last with dist all-ones accepted as occupied.
REQ-031 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable, in_ready 0; out_ready high -> next cycle in_ready 1, list empty.
REQ-032 SHALL cover: reset_n pulsed low asynchronously mid-VOTE -> out_valid never asserts, all outputs at reset values immediately.

Source files
------------

// File: rtl/k_sel_vote.sv
// k-nearest-neighbour selector: keeps the K smallest (distance, class) candidates, then majority-votes the class.
// Optional K_SEL_TIE_NEAREST_EN: count ties go to the class with the nearer member (default: lower class index).
module k_sel_vote #(
   parameter int K       = 5,
   parameter int DIST_W  = 19,
   parameter int CLASS_W = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DIST_W-1:0]  dist_a,
   input  logic [DIST_W-1:0]  dist_b,
   input  logic [CLASS_W-1:0] class_a,
   input  logic [CLASS_W-1:0] class_b,
   input  logic               b_en,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] vote_class,
   output logic [4:0]         vote_count,
   output logic [DIST_W-1:0]  nearest_dist,
   output logic               busy
);
   localparam int NCLASS = 2 ** CLASS_W;

   typedef enum logic [1:0] {COLLECT, VOTE, DONE} state_t;
   state_t state_q, state_d;

   logic [DIST_W-1:0]  dist_q [K];
   logic [DIST_W-1:0]  dist_d [K];
   logic [CLASS_W-1:0] cls_q  [K];
   logic [CLASS_W-1:0] cls_d  [K];
   logic [K-1:0]       occ_q, occ_d;

   logic [CLASS_W-1:0] idx_q, idx_d;
   logic [CLASS_W-1:0] best_class_q, best_class_d;
   logic [4:0]         best_count_q, best_count_d;
   logic [4:0]         best_rank_q, best_rank_d;

   logic [DIST_W-1:0]  m1_dist [K];
   logic [DIST_W-1:0]  m2_dist [K];
   logic [CLASS_W-1:0] m1_cls  [K];
   logic [CLASS_W-1:0] m2_cls  [K];
   logic [K-1:0]       m1_occ, m2_occ, ins_a, ins_b;
   logic               accept, take;
   logic [4:0]         vote_cnt, vote_rank;

   assign accept = in_valid && (state_q == COLLECT);

   // The list stays sorted with occupied entries first, so ins_* is monotonic:
   // the first set bit is the insertion slot and everything after it shifts down by one.
   for (genvar gi = 0; gi < K; gi++) begin : g_ins
      assign ins_a[gi] = !occ_q[gi] || (dist_a < dist_q[gi]);
      assign ins_b[gi] = !m1_occ[gi] || (dist_b < m1_dist[gi]);
      if (gi == 0) begin : g_head
         assign m1_dist[gi] = ins_a[gi] ? dist_a  : dist_q[gi];
         assign m1_cls[gi]  = ins_a[gi] ? class_a : cls_q[gi];
         assign m1_occ[gi]  = ins_a[gi] | occ_q[gi];
         assign m2_dist[gi] = ins_b[gi] ? dist_b  : m1_dist[gi];
         assign m2_cls[gi]  = ins_b[gi] ? class_b : m1_cls[gi];
         assign m2_occ[gi]  = ins_b[gi] | m1_occ[gi];
      end else begin : g_body
         assign m1_dist[gi] = !ins_a[gi] ? dist_q[gi] : (ins_a[gi-1] ? dist_q[gi-1] : dist_a);
         assign m1_cls[gi]  = !ins_a[gi] ? cls_q[gi]  : (ins_a[gi-1] ? cls_q[gi-1]  : class_a);
         assign m1_occ[gi]  = !ins_a[gi] ? occ_q[gi]  : (ins_a[gi-1] ? occ_q[gi-1]  : 1'b1);
         assign m2_dist[gi] = !ins_b[gi] ? m1_dist[gi] : (ins_b[gi-1] ? m1_dist[gi-1] : dist_b);
         assign m2_cls[gi]  = !ins_b[gi] ? m1_cls[gi]  : (ins_b[gi-1] ? m1_cls[gi-1]  : class_b);
         assign m2_occ[gi]  = !ins_b[gi] ? m1_occ[gi]  : (ins_b[gi-1] ? m1_occ[gi-1]  : 1'b1);
      end
   end

   // Count of the class under evaluation and the rank of its nearest member.
   always_comb begin
      vote_cnt  = '0;
      vote_rank = 5'(K);
      for (int i = K - 1; i >= 0; i--) begin
         if (occ_q[i] && (cls_q[i] == idx_q)) begin
            vote_cnt  = vote_cnt + 5'd1;
            vote_rank = 5'(i);
         end
      end
   end

`ifdef K_SEL_TIE_NEAREST_EN
   assign take = (vote_cnt > best_count_q) ||
                 ((vote_cnt == best_count_q) && (vote_cnt != '0) && (vote_rank < best_rank_q));
`else
   assign take = vote_cnt > best_count_q;
`endif

   always_comb begin
      state_d      = state_q;
      dist_d       = dist_q;
      cls_d        = cls_q;
      occ_d        = occ_q;
      idx_d        = idx_q;
      best_class_d = best_class_q;
      best_count_d = best_count_q;
      best_rank_d  = best_rank_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               dist_d = b_en ? m2_dist : m1_dist;
               cls_d  = b_en ? m2_cls  : m1_cls;
               occ_d  = b_en ? m2_occ  : m1_occ;
               if (in_last) begin
                  state_d = VOTE;
                  idx_d   = '0;
               end
            end
         end
         VOTE: begin
            if (take) begin
               best_class_d = idx_q;
               best_count_d = vote_cnt;
               best_rank_d  = vote_rank;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == CLASS_W'(NCLASS - 1)) state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d      = COLLECT;
               occ_d        = '0;
               best_class_d = '0;
               best_count_d = '0;
               best_rank_d  = 5'(K);
               for (int i = 0; i < K; i++) begin
                  dist_d[i] = '1;
                  cls_d[i]  = '0;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= COLLECT;
         occ_q        <= '0;
         idx_q        <= '0;
         best_class_q <= '0;
         best_count_q <= '0;
         best_rank_q  <= 5'(K);
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= '1;
            cls_q[i]  <= '0;
         end
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         idx_q        <= idx_d;
         best_class_q <= best_class_d;
         best_count_q <= best_count_d;
         best_rank_q  <= best_rank_d;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= dist_d[i];
            cls_q[i]  <= cls_d[i];
         end
      end
   end

   // Empty entries hold all-ones, so entry 0 is the nearest distance in every case.
   assign nearest_dist = dist_q[0];
   assign in_ready     = (state_q == COLLECT);
   assign busy         = (state_q != COLLECT);
   assign out_valid    = (state_q == DONE);
   assign vote_class   = best_class_q;
   assign vote_count   = best_count_q;
endmodule

// File: tb/tb_k_sel_vote.sv
// Directed bench for k_sel_vote (K=5, DIST_W=19, CLASS_W=2): vector table of query beats plus handshake/reset sequences.
module tb_k_sel_vote;
   localparam logic [18:0] ONES = '1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [18:0] dist_a = '0, dist_b = '0;
   logic [1:0]  class_a = '0, class_b = '0;
   logic        b_en = 1'b0, in_last = 1'b0;
   logic        out_valid, out_ready = 1'b0;
   logic [1:0]  vote_class;
   logic [4:0]  vote_count;
   logic [18:0] nearest_dist;
   logic        busy;

   int checks = 0;
   int errors = 0;

   k_sel_vote #(.K(5), .DIST_W(19), .CLASS_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .dist_a(dist_a), .dist_b(dist_b), .class_a(class_a), .class_b(class_b),
      .b_en(b_en), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .vote_class(vote_class), .vote_count(vote_count), .nearest_dist(nearest_dist), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        last;
      logic        ben;
      logic [18:0] da;
      logic [1:0]  ca;
      logic [18:0] db;
      logic [1:0]  cb;
      logic [1:0]  exp_class;
      logic [4:0]  exp_count;
      logic [18:0] exp_near;
   } vec_t;

   vec_t tbl [32];
   int   nvec = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic last, input logic ben, input logic [18:0] da, input logic [1:0] ca,
                      input logic [18:0] db, input logic [1:0] cb,
                      input logic [1:0] ec, input logic [4:0] en, input logic [18:0] ed);
      tbl[nvec] = '{last, ben, da, ca, db, cb, ec, en, ed};
      nvec++;
   endtask

   // Drives one beat (called away from the clock edge); for a last beat it waits for
   // the result, checks it, and completes the output handshake.
   task automatic run_beat(input vec_t v, input string tag);
      int n;
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1; in_last = v.last; b_en = v.ben;
      dist_a = v.da; class_a = v.ca; dist_b = v.db; class_b = v.cb;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (v.last) begin
         n = 1;
         while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         chk({tag, "_latency"}, n, 5);
         chk({tag, "_class"}, vote_class, v.exp_class);
         chk({tag, "_count"}, vote_count, v.exp_count);
         chk({tag, "_nearest"}, nearest_dist, v.exp_near);
         chk({tag, "_busy_done"}, busy, 1);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({tag, "_out_valid_clear"}, out_valid, 0);
      end
   endtask

   initial begin
      vec_t v;
      logic [1:0]  h_class;
      logic [4:0]  h_count;
      logic [18:0] h_near;
      logic        seen;

      // Three-beat query: list 2,4,7,9,10; class 1 holds three entries.
      add(0, 1, 10, 1, 4, 2, 0, 0, 0);
      add(0, 1, 7, 1, 2, 1, 0, 0, 0);
      add(1, 0, 9, 3, 0, 0, 1, 3, 2);
      // Six equal distances: first five by arrival kept (c0,c1,c2,c3,c3), late c1 dropped.
      add(0, 1, 5, 0, 5, 1, 0, 0, 0);
      add(0, 1, 5, 2, 5, 3, 0, 0, 0);
      add(1, 1, 5, 3, 5, 1, 3, 2, 5);
      // 20 down to 7 over seven beats; only 7..11 (all class 3) survive.
      for (int i = 0; i < 7; i++)
         add(i == 6, 1, 19'(20 - 2 * i), (i >= 5) ? 2'd3 : 2'd0,
             19'(19 - 2 * i), (i >= 4) ? 2'd3 : 2'd0, 3, 5, 7);
      // 2/2 tie between classes 2 and 3.
      add(0, 1, 5, 2, 5, 3, 0, 0, 0);
      add(1, 1, 6, 3, 6, 2, 2, 2, 5);
      add(0, 1, 5, 3, 5, 2, 0, 0, 0);
`ifdef K_SEL_TIE_NEAREST_EN
      add(1, 1, 6, 2, 6, 3, 3, 2, 5);
      add(1, 1, 1, 3, 3, 2, 3, 1, 1);
`else
      add(1, 1, 6, 2, 6, 3, 2, 2, 5);
      add(1, 1, 1, 3, 3, 2, 2, 1, 1);
`endif
      // Single beat, zero distance; then lane b ignored when b_en is low.
      add(1, 0, 0, 2, 0, 0, 2, 1, 0);
      add(1, 0, 8, 1, 1, 3, 1, 1, 8);

      // Reset state.
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_vote_class", vote_class, 0);
      chk("rst_vote_count", vote_count, 0);
      chk("rst_nearest", nearest_dist, ONES);
      #5 reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);

      for (int i = 0; i < nvec; i++) begin
         run_beat(tbl[i], $sformatf("vec%0d", i));
         $display("beat %0d: last=%0d b_en=%0d a=(%0d,c%0d) b=(%0d,c%0d) -> class=%0d count=%0d nearest=%0d",
                  i, tbl[i].last, tbl[i].ben, tbl[i].da, tbl[i].ca, tbl[i].db, tbl[i].cb,
                  vote_class, vote_count, nearest_dist);
      end

      // DONE held with out_ready low for 10 cycles while junk is offered on the input.
      run_beat(tbl[0], "hold_b0");
      run_beat(tbl[1], "hold_b1");
      in_valid = 1'b1; in_last = 1'b1; b_en = 1'b0; dist_a = 9; class_a = 3;
      @(posedge clk); #1;
      dist_a = 1; class_a = 0; b_en = 1'b1; dist_b = 0; class_b = 2;
      for (int n = 0; n < 20 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      chk("hold_out_valid", out_valid, 1);
      h_class = vote_class; h_count = vote_count; h_near = nearest_dist;
      chk("hold_class", h_class, 1);
      chk("hold_count", h_count, 3);
      chk("hold_nearest", h_near, 2);
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (!out_valid || in_ready || vote_class !== h_class || vote_count !== h_count ||
             nearest_dist !== h_near) seen = 1'b1;
      end
      chk("hold_stable_10", seen, 0);
      $display("hold: 10 cycles out_ready low, class=%0d count=%0d nearest=%0d", vote_class, vote_count, nearest_dist);
      in_valid = 1'b0; in_last = 1'b0; b_en = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_in_ready", in_ready, 1);
      chk("release_busy", busy, 0);
      chk("release_count", vote_count, 0);
      chk("release_nearest_empty", nearest_dist, ONES);
      v = '{1'b1, 1'b0, 19'd15, 2'd2, 19'd0, 2'd0, 2'd2, 5'd1, 19'd15};
      run_beat(v, "after_release");

      // Asynchronous reset in the middle of VOTE.
      in_valid = 1'b1; in_last = 1'b1; b_en = 1'b0; dist_a = 3; class_a = 1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      chk("midvote_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("midvote_rst_out_valid", out_valid, 0);
      chk("midvote_rst_busy", busy, 0);
      chk("midvote_rst_in_ready", in_ready, 1);
      chk("midvote_rst_class", vote_class, 0);
      chk("midvote_rst_count", vote_count, 0);
      chk("midvote_rst_nearest", nearest_dist, ONES);
      @(posedge clk); #3 reset_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("midvote_no_result", seen, 0);
      $display("midvote reset: out_valid seen=%0d", seen);

      // Reset then immediate last beat at all-ones distance: stored as occupied.
      v = '{1'b1, 1'b0, ONES, 2'd1, 19'd0, 2'd0, 2'd1, 5'd1, ONES};
      run_beat(v, "ones_dist");

      // Reset mid-COLLECT abandons the partial list.
      v = '{1'b0, 1'b1, 19'd1, 2'd3, 19'd2, 2'd3, 2'd0, 5'd0, 19'd0};
      run_beat(v, "abandon_b0");
      #3 reset_n = 1'b0;
      @(posedge clk); #3 reset_n = 1'b1;
      chk("abandon_nearest", nearest_dist, ONES);
      v = '{1'b1, 1'b0, 19'd9, 2'd0, 19'd0, 2'd0, 2'd0, 5'd1, 19'd9};
      run_beat(v, "abandon_fresh");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
